// File: rtl/dla_wb_pkg.sv
// Shared types and constants for the requantization write-back controller.
package dla_wb_pkg;

    localparam int unsigned HWORD    = 16;
    localparam int unsigned WORD     = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned ADDR_INC = 4;

    localparam logic [STRB_W-1:0] STRB_FULL = 4'b1111;
    localparam logic [STRB_W-1:0] STRB_LO   = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wb_state_e;

    // Data half of a write request; the address travels alongside since its width is a parameter.
    typedef struct packed {
        logic [WORD-1:0]   data;
        logic [STRB_W-1:0] strb;
    } wb_payload_t;

endpackage

// File: rtl/requan_wb_slot.sv
// One-entry valid/ready output register for write requests.
module requan_wb_slot
    import dla_wb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  wb_payload_t       ld_pay,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WORD-1:0]   wb_data,
    output logic [STRB_W-1:0] wb_strb,
    output logic              slot_free_c
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    wb_payload_t       pay_q, pay_d;

    // Free when empty or when the held request is accepted this cycle.
    assign slot_free_c = ~valid_q | wb_ready;

    // Load has priority so a reload in the draining cycle leaves no bubble.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        pay_d   = pay_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = ld_addr;
            pay_d   = ld_pay;
        end else if (wb_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; contents hold while valid and not ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            pay_q   <= pay_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_addr  = addr_q;
    assign wb_data  = pay_q.data;
    assign wb_strb  = pay_q.strb;

endmodule

// File: rtl/requan_wb_ctrl.sv
// Write-back controller: packs 16-bit results into 32-bit words and writes them out.
module requan_wb_ctrl
    import dla_wb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              res_valid,
    input  logic [HWORD-1:0]  res_data,
    output logic              res_ready,
    output logic              stall,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WORD-1:0]   wb_data,
    output logic [STRB_W-1:0] wb_strb,
    input  logic              wb_ready,
    output logic              busy,
    output logic              done
);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HWORD-1:0]  lo_q, lo_d;
    logic              lo_vld_q, lo_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              slot_free_c;
    logic              res_ready_c;
    logic              accept_c;
    logic              load_c;
    wb_payload_t       ld_pay_c;

    requan_wb_slot #(
        .ADDR_W (ADDR_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .ld_addr     (addr_q),
        .ld_pay      (ld_pay_c),
        .wb_ready    (wb_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_strb     (wb_strb),
        .slot_free_c (slot_free_c)
    );

    // Result acceptance: a pending half only blocks when the slot cannot take the pair.
    always_comb begin
        res_ready_c = (state_q == RUN) && (acc_q < cnt_q) && (!lo_vld_q || slot_free_c);
        accept_c    = res_valid && res_ready_c;
    end

    // Next-state, packer, counters and write-slot load.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        lo_vld_d = lo_vld_q;
        load_c   = 1'b0;
        ld_pay_c = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d    = cfg_count;
                    addr_d   = cfg_base_addr & ~ADDR_W'(3);
                    acc_d    = '0;
                    lo_vld_d = 1'b0;
                    state_d  = (cfg_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept_c) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (!lo_vld_q) begin
                        lo_d     = res_data;
                        lo_vld_d = 1'b1;
                    end else begin
                        load_c        = 1'b1;
                        ld_pay_c.data = {res_data, lo_q};
                        ld_pay_c.strb = STRB_FULL;
                        addr_d        = addr_q + ADDR_W'(ADDR_INC);
                        lo_vld_d      = 1'b0;
                    end
                    if (acc_q + CNT_W'(1) == cnt_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (lo_vld_q) begin
                    if (slot_free_c) begin
                        load_c        = 1'b1;
                        ld_pay_c.data = {HWORD'(0), lo_q};
                        ld_pay_c.strb = STRB_LO;
                        addr_d        = addr_q + ADDR_W'(ADDR_INC);
                        lo_vld_d      = 1'b0;
                    end
                end else if (slot_free_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Controller registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            lo_q     <= '0;
            lo_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            lo_q     <= lo_d;
            lo_vld_q <= lo_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign res_ready = res_ready_c;
    assign stall     = busy_q & ~res_ready_c;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_requan_wb_ctrl.sv
// Self-checking bench for requan_wb_ctrl: job table, write scoreboard, reset sequence.
module tb_requan_wb_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [CNT_W-1:0]  cfg_count;
    logic              res_valid;
    logic [15:0]       res_data;
    logic              res_ready;
    logic              stall;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic [3:0]        wb_strb;
    logic              wb_ready;
    logic              busy;
    logic              done;

    requan_wb_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_count     (cfg_count),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_strb       (wb_strb),
        .wb_ready      (wb_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        int          cnt;
        logic [31:0] base;
        logic [15:0] d0;
        int          hold;       // wb_ready low cycles on the second write
        bit          gap;        // random res_valid gaps
        bit          disturb;    // second start and cfg change mid-job
        int          exp_lat;    // start to done cycles, -1 = not checked
        int          exp_stall;  // stall cycles while results remain
        int          exp_writes;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  held;
    bit   held_v;
    int   errors;
    int   checks;
    int   cyc;
    int   acc_n;
    int   job_cnt;
    int   wr_seen;
    int   stall_run;
    int   done_cyc;
    int   last_wr_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One clock: check at the falling edge, then advance to just after the rising edge.
    task automatic step();
        logic exp_rr;
        wr_t  w;
        @(negedge clk);
        exp_rr = busy && (acc_n < job_cnt) && ((acc_n % 2) == 0 || !wb_valid || wb_ready);
        chk("res_ready", 32'(res_ready), 32'(exp_rr));
        chk("stall", 32'(stall), 32'(busy & ~exp_rr));
        if (stall && acc_n < job_cnt) stall_run++;
        if (wb_valid) begin
            if (held_v) begin
                chk("hold_addr", wb_addr, held.addr);
                chk("hold_data", wb_data, held.data);
                chk("hold_strb", 32'(wb_strb), 32'(held.strb));
            end
            if (wb_ready) begin
                wr_seen++;
                last_wr_cyc = cyc;
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_addr", wb_addr, w.addr);
                    chk("wb_data", wb_data, w.data);
                    chk("wb_strb", 32'(wb_strb), 32'(w.strb));
                end
            end else begin
                held_v = 1'b1;
                held.addr = wb_addr;
                held.data = wb_data;
                held.strb = wb_strb;
            end
        end else if (held_v) begin
            fail("wb_valid_dropped_before_ready");
            held_v = 1'b0;
        end
        if (res_valid && res_ready) acc_n++;
        if (done && done_cyc < 0) done_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_expected(input int cnt, input logic [31:0] base, input logic [15:0] d0);
        wr_t         w;
        logic [15:0] lo;
        logic [15:0] hi;
        for (int k = 0; k < (cnt + 1) / 2; k++) begin
            w.addr = (base & ~32'h3) + 32'(4 * k);
            lo = d0 + 16'(2 * k);
            if (2 * k + 1 < cnt) begin
                hi = d0 + 16'(2 * k + 1);
                w.data = {hi, lo};
                w.strb = 4'hF;
            end else begin
                w.data = {16'h0000, lo};
                w.strb = 4'h3;
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic begin_job(input int cnt, input logic [31:0] base, input logic [15:0] d0);
        exp_q.delete();
        push_expected(cnt, base, d0);
        acc_n       = 0;
        job_cnt     = cnt;
        wr_seen     = 0;
        stall_run   = 0;
        done_cyc    = -1;
        last_wr_cyc = -1;
        held_v      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int start_cyc;
        int hold_left;
        bit hold_used;
        hold_left = 0;
        hold_used = 1'b0;
        begin_job(v.cnt, v.base, v.d0);
        cfg_count     = 16'(v.cnt);
        cfg_base_addr = v.base;
        res_valid     = 1'b0;
        wb_ready      = 1'b1;
        start         = 1'b1;
        start_cyc     = cyc;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (v.disturb) begin
            cfg_count     = 16'd7;
            cfg_base_addr = 32'hDEAD0000;
        end
        for (int i = 0; i < 300 && done_cyc < 0; i++) begin
            start     = v.disturb && (i == 2 || i == 3);
            res_valid = (acc_n < job_cnt) && (!v.gap || $urandom_range(0, 1) == 1);
            res_data  = v.d0 + 16'(acc_n);
            if (v.hold > 0 && !hold_used && wb_valid && wr_seen == 1) begin
                hold_left = v.hold;
                hold_used = 1'b1;
            end
            wb_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            step();
        end
        start     = 1'b0;
        res_valid = 1'b0;
        wb_ready  = 1'b1;
        if (done_cyc < 0) begin
            fail("done_timeout");
        end else begin
            if (v.exp_lat >= 0) chk("done_latency", 32'(done_cyc - start_cyc), 32'(v.exp_lat));
            if (v.cnt > 0) chk("done_after_last_write", 32'(done_cyc), 32'(last_wr_cyc + 1));
            chk("stall_cycles", 32'(stall_run), 32'(v.exp_stall));
            chk("write_count", 32'(wr_seen), 32'(v.exp_writes));
            chk("writes_left", 32'(exp_q.size()), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
        end
        step();
        chk("no_restart", 32'(busy), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_res_ready"}, 32'(res_ready), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_addr"}, wb_addr, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_strb"}, 32'(wb_strb), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t fresh;
        bit   got_valid;

        vecs[0] = '{4, 32'h0000_1000, 16'h0001, 0, 1'b0, 1'b0,  6, 0, 2};
        vecs[1] = '{3, 32'h0000_2000, 16'h0001, 0, 1'b0, 1'b0,  6, 0, 2};
        vecs[2] = '{6, 32'h0000_5000, 16'h0010, 5, 1'b0, 1'b0, -1, 4, 3};
        vecs[3] = '{0, 32'h0000_6000, 16'h0000, 0, 1'b0, 1'b0,  1, 0, 0};
        vecs[4] = '{5, 32'h0000_7000, 16'h0100, 0, 1'b0, 1'b1,  8, 0, 3};
        vecs[5] = '{4, 32'hFFFF_FFFC, 16'h00A0, 0, 1'b0, 1'b0,  6, 0, 2};
        vecs[6] = '{7, 32'h0000_8003, 16'h0200, 0, 1'b1, 1'b0, -1, 0, 4};
        vecs[7] = '{2, 32'h0000_9000, 16'h0300, 0, 1'b0, 1'b0,  4, 0, 1};

        errors = 0; checks = 0; cyc = 0;
        acc_n = 0; job_cnt = 0; held_v = 1'b0;
        wr_seen = 0; stall_run = 0; done_cyc = -1; last_wr_cyc = -1;
        rst = 1'b0; start = 1'b0; cfg_base_addr = '0; cfg_count = '0;
        res_valid = 1'b0; res_data = '0; wb_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while a write is held in the slot, then a fresh job from a new base.
        begin_job(4, 32'h0000_3000, 16'h0030);
        cfg_count     = 16'd4;
        cfg_base_addr = 32'h0000_3000;
        wb_ready      = 1'b0;
        start         = 1'b1;
        step();
        start     = 1'b0;
        got_valid = 1'b0;
        for (int i = 0; i < 20 && !got_valid; i++) begin
            res_valid = (acc_n < job_cnt);
            res_data  = 16'h0030 + 16'(acc_n);
            step();
            got_valid = wb_valid;
        end
        chk("wb_valid_before_reset", 32'(wb_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        res_valid = 1'b0;
        exp_q.delete();
        held_v  = 1'b0;
        acc_n   = 0;
        job_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        wb_ready = 1'b1;
        fresh = '{4, 32'h0000_4000, 16'h0040, 0, 1'b0, 1'b0, 6, 0, 2};
        run_vec(fresh);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/requan_wb_ctrl.md
# requan_wb_ctrl

Write-back controller for the DLA requantization stage. It accepts the stream of 16-bit requantized results, packs pairs into 32-bit words and writes them to the output buffer at incrementing addresses through a valid/ready write port. It also drives the `stall` used by the requantization pipeline registers. It sits between the final requantization pipeline register and the output-buffer/AXI write master, and runs one job per `start` pulse.

## Interface
- `ADDR_W`, default 32: write-address width.
- `CNT_W`, default 16: result-count width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle job start; sampled only in IDLE.
- `cfg_base_addr` in ADDR_W: first word address; bits [1:0] are ignored and treated as 0.
- `cfg_count` in CNT_W: number of 16-bit results in the job.
- `res_valid` in 1: a requantized result is present.
- `res_data` in 16: the requantized result.
- `res_ready` out 1: the result is taken this cycle when `res_valid` is also high.
- `stall` out 1: `busy & ~res_ready`; holds the upstream pipeline registers.
- `wb_valid` out 1: write request.
- `wb_addr` out ADDR_W: write word address.
- `wb_data` out 32: write data.
- `wb_strb` out 4: byte strobes.
- `wb_ready` in 1: write accepted when `wb_valid` is high.
- `busy` out 1: state is not IDLE.
- `done` out 1: single-cycle pulse at job end.

## Operation
- States and transitions:
  - IDLE: on `start`, latch the configuration, clear counters, go to RUN; if `cfg_count==0`, go to DONE instead.
  - RUN: accept results; when the accepted count reaches the latched count, go to FLUSH.
  - FLUSH: emit the pending half-word, then wait until `wb_valid==0`; go to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- Configuration is latched at start; changes to `cfg_*` during a job have no effect.
- `start` while `busy` is ignored.
- Packing:
  - The first result of a pair goes to the half register (`lo_q`, `lo_vld=1`).
  - The second result forms `wb_data={res_data, lo_q}` with `wb_strb=4'b1111`.
- Odd count: in FLUSH, the pending `lo_q` is written as `{16'h0, lo_q}` with `wb_strb=4'b0011`.
- Output slot: a single entry. `wb_valid`, `wb_addr`, `wb_data` and `wb_strb` hold stable until `wb_ready`.
- Address: the first write goes to `cfg_base_addr`. `wb_addr` increases by 4 per issued write, wrapping modulo 2^ADDR_W.
- `res_ready` is high in RUN when the accepted count is below the latched count and one of these holds:
  - `lo_vld==0`, or
  - the slot is free or draining this cycle (`~wb_valid | wb_ready`).
- `res_ready` is combinational from `wb_ready`.
- Accepted-count counter width is CNT_W; the maximum count is 2^CNT_W−1.
- Back-to-back writes: when `wb_ready` and a new pair completion occur in the same cycle, the slot reloads with no bubble.
- Reset mid-job: all state clears immediately and the in-flight write is dropped. Software must restart the job.

## Timing
- Reset values: `res_ready=0`, `stall=0`, `wb_valid=0`, `wb_addr=0`, `wb_data=0`, `wb_strb=0`, `busy=0`, `done=0`, state IDLE.
- Start: `start` at cycle T gives `busy=1` and RUN at T+1; `res_ready` can be 1 at T+1.
- Second half accepted at cycle N gives `wb_valid=1` at N+1.
- Sustained throughput: one result per cycle, one write per two cycles, with `wb_ready` held high.
- Last write accepted at cycle M gives DONE at M+1 (`done=1`) and IDLE at M+2.
- With `cfg_count==0`: start at T, `done` at T+1.
- Odd count: FLUSH loads the partial write on the first cycle the slot is free.

## Structure
- Package `dla_wb_pkg` holds:
  - the `wb_state_e` enum (IDLE, RUN, FLUSH, DONE);
  - the constants `HWORD=16`, `WORD=32`, `STRB_FULL=4'b1111`, `STRB_LO=4'b0011`, `ADDR_INC=4`.
- Sub-module `requan_wb_slot` is the one-entry valid/ready output register holding address, data and strobe. The FSM, packer and counters stay in the top module.

## Test plan
- Count 4, base 0x1000, results 0x0001..0x0004, `wb_ready` high: writes are 0x1000←0x00020001 and 0x1004←0x00040003, both with strobe 0xF; `done` one cycle after the second write.
- Count 3, base 0x2000: the second write is 0x2004←0x00000003 with strobe 0x3.
- Count 6, `wb_ready` low for 5 cycles during the second write: `wb_*` stays stable, and `res_ready=0` / `stall=1` once the half register is full; no result is lost or duplicated.
- Count 0: `done` pulses at T+1, and no `wb_valid` is ever asserted.
- Second `start` and changed `cfg_count` mid-job: both are ignored, and the original job completes unchanged.
- `rst` low mid-job with `wb_valid=1`: all outputs go to 0 asynchronously, and a fresh start then runs normally from the new base.
